// File: rtl/v1_filter_pulse_ctrl_pkg.sv
// Shared constants, state encoding and event bundle for the
// variant-1 pulse-capture controller.
package v1_parameters;

    localparam int V1_DATA_W = 16;
    localparam int V1_TS_W   = 32;
    localparam int V1_DLY_W  = 8;

    localparam logic [1:0] ADDR_THRESH = 2'd0;
    localparam logic [1:0] ADDR_PEAK   = 2'd1;
    localparam logic [1:0] ADDR_HOLD   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam logic signed [V1_DATA_W-1:0] RST_THRESH = 16'sd100;
    localparam logic [V1_DLY_W-1:0]         RST_PEAK   = 8'd8;
    localparam logic [V1_DLY_W-1:0]         RST_HOLD   = 8'd21;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PEAK,
        HOLD
    } state_t;

    typedef struct packed {
        logic signed [V1_DATA_W-1:0] amp;
        logic [V1_TS_W-1:0]          ts;
    } evt_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/v1_evt_outbuf.sv
// One-deep valid/ready event register; a sample that finds the
// stage full and not draining is dropped and counted.
module v1_evt_outbuf
    import v1_parameters::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  evt_t       i_evt,
    input  logic       i_ready,
    output logic       o_valid,
    output evt_t       o_evt,
    output logic [7:0] o_drop_cnt
);

    logic       r_valid;
    evt_t       r_evt;
    logic [7:0] r_drop;

    // Load on empty or same-cycle pop, otherwise drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_evt   <= '0;
            r_drop  <= 8'd0;
        end else if (i_load) begin
            if (!r_valid || i_ready) begin
                r_valid <= 1'b1;
                r_evt   <= i_evt;
            end else begin
                r_drop  <= sat_inc8(r_drop);
            end
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_evt      = r_evt;
    assign o_drop_cnt = r_drop;

endmodule

// File: rtl/v1_filter_pulse_ctrl.sv
// Pulse-capture FSM, register file and shaper clear for the v1 shaper.
// Optional pile-up rejection is built when V1_PILEUP_REJECT_EN is defined.
module v1_filter_pulse_ctrl
    import v1_parameters::*;
#(
    parameter int SIZE_FILTER_DATA = V1_DATA_W,
    parameter int SIZE_TS          = V1_TS_W,
    parameter int SIZE_DELAY       = V1_DLY_W
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cfg_we,
    input  logic [1:0]                         cfg_addr,
    input  logic [15:0]                        cfg_wdata,
    input  logic signed [SIZE_FILTER_DATA-1:0] filt_data,
    output logic                               filt_clr,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] evt_amp,
    output logic [SIZE_TS-1:0]                 evt_ts,
    output logic [7:0]                         drop_cnt,
`ifdef V1_PILEUP_REJECT_EN
    output logic [7:0]                         pileup_cnt,
`endif
    output logic                               busy
);

    localparam logic [SIZE_DELAY-1:0] DLY_ONE = 1;

    logic signed [SIZE_FILTER_DATA-1:0] r_threshold;
    logic [SIZE_DELAY-1:0]              r_peak_delay;
    logic [SIZE_DELAY-1:0]              r_holdoff;
    logic                               r_enable;
    logic                               r_filt_clr;
    logic [SIZE_TS-1:0]                 r_ts;
    logic signed [SIZE_FILTER_DATA-1:0] r_prev;
    state_t                             r_state;
    logic [SIZE_DELAY-1:0]              r_cnt;
    logic [SIZE_TS-1:0]                 r_ts_lat;
    logic                               r_busy;

    logic                  w_cross;
    logic [SIZE_DELAY-1:0] w_hold_load;
    logic                  w_peak_done;
    logic                  w_direct;
    logic                  w_sample;
    logic                  w_pile_hit;
    logic                  w_load;
    evt_t                  w_evt;
    evt_t                  w_out;

    // Register file; clear bit is a pulse and never stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_threshold  <= RST_THRESH;
            r_peak_delay <= RST_PEAK;
            r_holdoff    <= RST_HOLD;
            r_enable     <= 1'b0;
            r_filt_clr   <= 1'b0;
        end else begin
            r_filt_clr <= 1'b0;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_THRESH: r_threshold  <= $signed(cfg_wdata);
                    ADDR_PEAK:   r_peak_delay <= cfg_wdata[SIZE_DELAY-1:0];
                    ADDR_HOLD:   r_holdoff    <= cfg_wdata[SIZE_DELAY-1:0];
                    default: begin
                        r_enable   <= cfg_wdata[CTRL_EN_BIT];
                        r_filt_clr <= cfg_wdata[CTRL_CLR_BIT];
                    end
                endcase
            end
        end
    end

    // Free-running timestamp and previous-sample history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts   <= '0;
            r_prev <= '0;
        end else begin
            r_ts   <= r_ts + 1'b1;
            r_prev <= filt_data;
        end
    end

    assign w_cross     = (filt_data >= r_threshold) && (r_prev < r_threshold);
    assign w_hold_load = (r_holdoff == '0) ? '0 : r_holdoff - DLY_ONE;
    assign w_peak_done = (r_state == PEAK) && (r_cnt == '0);
    assign w_direct    = (r_state == ARMED) && w_cross && (r_peak_delay == '0);
    assign w_sample    = r_enable && (w_peak_done || w_direct);

`ifdef V1_PILEUP_REJECT_EN
    logic       r_pile;
    logic [7:0] r_pileup_cnt;
    assign w_pile_hit = w_peak_done && (r_pile || w_cross);
    assign pileup_cnt = r_pileup_cnt;
`else
    assign w_pile_hit = 1'b0;
`endif

    assign w_load = w_sample && !w_pile_hit;

    // Direct samples carry the live timestamp, delayed ones the latch.
    always_comb begin
        w_evt     = '0;
        w_evt.amp = filt_data;
        w_evt.ts  = (r_state == PEAK) ? r_ts_lat : r_ts;
    end

    // Capture state machine with registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ts_lat <= '0;
            r_busy   <= 1'b0;
`ifdef V1_PILEUP_REJECT_EN
            r_pile       <= 1'b0;
            r_pileup_cnt <= 8'd0;
`endif
        end else if (!r_enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
`ifdef V1_PILEUP_REJECT_EN
            r_pile  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: r_state <= ARMED;
                ARMED: begin
                    if (w_cross) begin
                        r_ts_lat <= r_ts;
                        r_busy   <= 1'b1;
                        if (r_peak_delay == '0) begin
                            r_state <= HOLD;
                            r_cnt   <= w_hold_load;
                        end else begin
                            r_state <= PEAK;
                            r_cnt   <= r_peak_delay - DLY_ONE;
                        end
                    end
                end
                PEAK: begin
                    if (r_cnt == '0) begin
                        r_state <= HOLD;
                        r_cnt   <= w_hold_load;
`ifdef V1_PILEUP_REJECT_EN
                        r_pile <= 1'b0;
                        if (w_pile_hit)
                            r_pileup_cnt <= sat_inc8(r_pileup_cnt);
`endif
                    end else begin
                        r_cnt <= r_cnt - DLY_ONE;
`ifdef V1_PILEUP_REJECT_EN
                        if (w_cross)
                            r_pile <= 1'b1;
`endif
                    end
                end
                HOLD: begin
                    if (r_cnt == '0) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - DLY_ONE;
                    end
`ifdef V1_PILEUP_REJECT_EN
                    if (w_cross) begin
                        r_state      <= HOLD;
                        r_busy       <= 1'b1;
                        r_cnt        <= w_hold_load;
                        r_pileup_cnt <= sat_inc8(r_pileup_cnt);
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    v1_evt_outbuf u_outbuf (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_evt      (w_evt),
        .i_ready    (evt_ready),
        .o_valid    (evt_valid),
        .o_evt      (w_out),
        .o_drop_cnt (drop_cnt)
    );

    assign evt_amp  = w_out.amp;
    assign evt_ts   = w_out.ts;
    assign filt_clr = r_filt_clr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_v1_filter_pulse_ctrl.sv
// Directed bench for v1_filter_pulse_ctrl with an event scoreboard.
// Build with +define+V1_PILEUP_REJECT_EN to cover pile-up rejection.
module tb_v1_filter_pulse_ctrl;

    typedef struct {
        logic [15:0] amp;
        logic [31:0] ts;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [15:0]        cfg_wdata;
    logic signed [15:0] filt_data;
    logic               filt_clr;
    logic               evt_valid;
    logic               evt_ready;
    logic signed [15:0] evt_amp;
    logic [31:0]        evt_ts;
    logic [7:0]         drop_cnt;
    logic               busy;
`ifdef V1_PILEUP_REJECT_EN
    logic [7:0]         pileup_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] bts;
    exp_t        sb[$];

    always #5 clk = ~clk;

    v1_filter_pulse_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .filt_data  (filt_data),
        .filt_clr   (filt_clr),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_amp    (evt_amp),
        .evt_ts     (evt_ts),
        .drop_cnt   (drop_cnt),
`ifdef V1_PILEUP_REJECT_EN
        .pileup_cnt (pileup_cnt),
`endif
        .busy       (busy)
    );

    // Reference cycle count: the value the timestamp holds each cycle.
    always @(posedge clk)
        bts <= reset ? 32'd0 : bts + 32'd1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        nxt();
        cfg_we    = 1'b0;
    endtask

    // Pop the scoreboard on every accepted event.
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            chk("evt_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_amp", 64'($unsigned(evt_amp)), 64'(e.amp));
                chk("evt_ts", 64'(evt_ts), 64'(e.ts));
            end
        end
    end

    initial begin
        logic [15:0] t1;
        logic [31:0] ts1;
        int          v;
        int          pv;
        logic        xprev;
        reset     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'd0;
        filt_data = 16'sd0;
        evt_ready = 1'b1;
        t1        = 16'd0;

        // reset state
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_amp", 64'($unsigned(evt_amp)), 64'd0);
        chk("rst_ts", 64'(evt_ts), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_clr", 64'(filt_clr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef V1_PILEUP_REJECT_EN
        chk("rst_pileup", 64'(pileup_cnt), 64'd0);
`endif
        nxt();
        reset = 1'b0;
        wr(2'd3, 16'd1);
        repeat (5) nxt();

        // step 0->500 with default delay: latency pd+1, one event
        sb.push_back('{amp: 16'd500, ts: bts});
        filt_data = 16'sd500;
        @(negedge clk);
        chk("s1_busy_armed", 64'(busy), 64'd0);
        @(negedge clk);
        chk("s1_busy_peak", 64'(busy), 64'd1);
        repeat (7) @(negedge clk);
        chk("s1_valid_early", 64'(evt_valid), 64'd0);
        @(negedge clk);
        chk("s1_valid", 64'(evt_valid), 64'd1);
        repeat (40) nxt();
        chk("s1_single", 64'(sb.size()), 64'd0);
        filt_data = 16'sd0;
        repeat (30) nxt();

        // zero delay, ramp of 50 per cycle
        wr(2'd1, 16'd0);
        repeat (3) nxt();
        pv    = 0;
        xprev = 1'b0;
        for (int i = 0; i < 13; i++) begin
            v = i * 50;
            filt_data = 16'(v);
            if (v >= 100 && pv < 100)
                sb.push_back('{amp: 16'(v), ts: bts});
            @(negedge clk);
            chk("ramp_valid", 64'(evt_valid), 64'(xprev));
            xprev = (v >= 100 && pv < 100);
            pv = v;
            nxt();
        end
        repeat (30) nxt();
        filt_data = 16'sd0;
        wr(2'd1, 16'd8);
        repeat (30) nxt();

        // backpressure: hold first event, drop second
        evt_ready = 1'b0;
        ts1 = bts;
        sb.push_back('{amp: 16'd500, ts: bts});
        filt_data = 16'sd500;
        repeat (10) nxt();
        filt_data = 16'sd0;
        repeat (30) nxt();
        filt_data = 16'sd700;
        repeat (10) nxt();
        filt_data = 16'sd0;
        repeat (25) nxt();
        @(negedge clk);
        chk("bp_valid", 64'(evt_valid), 64'd1);
        chk("bp_amp_hold", 64'($unsigned(evt_amp)), 64'd500);
        chk("bp_ts_hold", 64'(evt_ts), 64'(ts1));
        chk("bp_drop1", 64'(drop_cnt), 64'd1);
        nxt();
        evt_ready = 1'b1;
        nxt();
        evt_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k == 0)
                sb.push_back('{amp: 16'd500, ts: bts});
            filt_data = 16'sd500;
            repeat (10) nxt();
            filt_data = 16'sd0;
            repeat (22) nxt();
        end
        @(negedge clk);
        chk("bp_drop_sat", 64'(drop_cnt), 64'd255);
        chk("bp_valid2", 64'(evt_valid), 64'd1);
        nxt();
        evt_ready = 1'b1;
        repeat (3) nxt();
        chk("bp_drained", 64'(sb.size()), 64'd0);

        // shaper clear pulse
        cfg_we    = 1'b1;
        cfg_addr  = 2'd3;
        cfg_wdata = 16'd3;
        @(negedge clk);
        chk("clr_before", 64'(filt_clr), 64'd0);
        nxt();
        cfg_we = 1'b0;
        @(negedge clk);
        chk("clr_pulse", 64'(filt_clr), 64'd1);
        nxt();
        @(negedge clk);
        chk("clr_after", 64'(filt_clr), 64'd0);
        nxt();
        repeat (3) nxt();

        // disable in the middle of PEAK
        filt_data = 16'sd500;
        repeat (3) nxt();
        wr(2'd3, 16'd0);
        @(negedge clk);
        chk("dis_busy_peak", 64'(busy), 64'd1);
        nxt();
        @(negedge clk);
        chk("dis_busy_idle", 64'(busy), 64'd0);
        repeat (15) nxt();
        @(negedge clk);
        chk("dis_no_evt", 64'(evt_valid), 64'd0);
        nxt();
        filt_data = 16'sd0;
        wr(2'd3, 16'd1);
        repeat (5) nxt();

        // second crossing five cycles after the first
`ifndef V1_PILEUP_REJECT_EN
        sb.push_back('{amp: 16'd500, ts: bts});
`endif
        filt_data = 16'sd500;
        repeat (2) nxt();
        filt_data = 16'sd0;
        repeat (3) nxt();
        filt_data = 16'sd500;
        repeat (40) nxt();
`ifdef V1_PILEUP_REJECT_EN
        chk("pile_cnt", 64'(pileup_cnt), 64'd1);
        chk("pile_drop", 64'(drop_cnt), 64'd255);
`endif
        chk("pile_sb", 64'(sb.size()), 64'd0);
        filt_data = 16'sd0;
        repeat (30) nxt();

        // reset during HOLD with a held event
        evt_ready = 1'b0;
        filt_data = 16'sd100;
        repeat (10) nxt();
        wr(2'd0, 16'd1000);
        @(negedge clk);
        chk("hr_valid", 64'(evt_valid), 64'd1);
        chk("hr_busy", 64'(busy), 64'd1);
        nxt();
        reset     = 1'b1;
        filt_data = 16'sd0;
        nxt();
        @(negedge clk);
        chk("hr_valid0", 64'(evt_valid), 64'd0);
        chk("hr_amp0", 64'($unsigned(evt_amp)), 64'd0);
        chk("hr_ts0", 64'(evt_ts), 64'd0);
        chk("hr_drop0", 64'(drop_cnt), 64'd0);
        chk("hr_clr0", 64'(filt_clr), 64'd0);
        chk("hr_busy0", 64'(busy), 64'd0);
`ifdef V1_PILEUP_REJECT_EN
        chk("hr_pile0", 64'(pileup_cnt), 64'd0);
`endif
        nxt();
        reset = 1'b0;
        wr(2'd3, 16'd1);
        evt_ready = 1'b1;
        repeat (3) nxt();
        sb.push_back('{amp: 16'd100, ts: bts});
        filt_data = 16'sd100;
        repeat (9) @(negedge clk);
        chk("hr_valid_early", 64'(evt_valid), 64'd0);
        @(negedge clk);
        chk("hr_valid_def", 64'(evt_valid), 64'd1);
        repeat (30) nxt();
        filt_data = 16'sd0;
        repeat (5) nxt();
        chk("final_sb", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/v1_filter_pulse_ctrl.md
# v1_filter_pulse_ctrl

Pulse-capture controller for the variant-1 trapezoidal shaper: watches the shaped filter output, arms on a threshold crossing, samples the flat-top amplitude after a programmable delay, and enforces a hold-off before re-arming. It owns the shaper's clear strobe and a small register file (threshold, peak delay, hold-off, control). Captured events leave through a one-deep valid/ready output stage to the readout logic.

## Interface
- SIZE_FILTER_DATA, 16, width of shaped filter sample (signed)
- SIZE_TS, 32, timestamp width
- SIZE_DELAY, 8, width of peak-delay and hold-off counters
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  0=threshold, 1=peak_delay, 2=holdoff, 3=control
- cfg_wdata  in  16  write data
- filt_data  in  SIZE_FILTER_DATA  shaped sample, signed, new value every clk
- filt_clr  out  1  one-cycle clear pulse to the shaper
- evt_valid  out  1  event available
- evt_ready  in  1  downstream accepts event
- evt_amp  out  SIZE_FILTER_DATA  sampled amplitude
- evt_ts  out  SIZE_TS  timestamp of threshold crossing
- drop_cnt  out  8  dropped events, saturating
- busy  out  1  FSM not in IDLE or ARMED

## Operation
- Registers and reset values: threshold=16'sd100; peak_delay=8; holdoff=21; control=0. Control bit0=enable; bit1=clear (write-1 pulse, not stored).
- Writing control with bit1=1 drives filt_clr=1 on the next cycle for exactly one cycle.
- Crossing: filt_data >= threshold AND previous sample < threshold (signed compare). The previous sample register resets to 0.
- FSM states:
  - IDLE: entered when enable=0.
  - ARMED: on a crossing, latch ts and load peak_delay; go to PEAK. If peak_delay=0, sample in the crossing cycle and go directly to HOLD.
  - PEAK: count down. The sample is taken at count 0, so amp = filt_data at cycle T+peak_delay, where T is the crossing cycle. Then go to HOLD and load holdoff.
  - HOLD: count down; at 0 go to ARMED. Re-arming also requires a fresh crossing, so a sample still above threshold does not retrigger.
- enable=0 forces IDLE from any state next cycle; a pending output event is kept.
- Timestamp: free-running SIZE_TS counter, wraps to 0, resets to 0, runs regardless of enable.
- Output stage: on a sample, load {amp, ts} if the stage is empty or is being popped that same cycle (evt_valid&&evt_ready). Otherwise drop the event and increment drop_cnt, saturating at 255.
- evt_amp/evt_ts are stable while evt_valid=1 and evt_ready=0.

## Timing
- All outputs reset to 0: evt_valid, evt_amp, evt_ts, drop_cnt, filt_clr, busy. FSM resets to IDLE.
- Register write takes effect the cycle after cfg_we.
- A write during PEAK/HOLD does not reload the running counter; it applies to the next event.
- evt_valid rises the cycle after sampling. Crossing to evt_valid latency = peak_delay+1 cycles.
- Minimum event spacing = peak_delay+holdoff+1 cycles.
- Simultaneous pop and load: the new event replaces the old one, valid stays 1, and there is no drop.
- Reset mid-operation clears the FSM, counters, output stage and drop_cnt in the same cycle. Register file returns to defaults.

## Configuration
- V1_PILEUP_REJECT_EN defined: a crossing detected in PEAK or HOLD marks the current or next-sampled event as pile-up. That event is discarded, not counted in drop_cnt. A separate saturating 8-bit output pileup_cnt increments, and hold-off restarts from holdoff.
- Undefined: crossings in PEAK/HOLD are ignored, there is no pileup_cnt port, and hold-off is never extended.

## Structure
- Add to v1_parameters:
  - register address constants and reset defaults
  - typedef enum {IDLE, ARMED, PEAK, HOLD} for the state
  - an event struct {amp, ts}
- Sub-module v1_evt_outbuf: the one-deep valid/ready register with drop counter. The FSM and register file stay in the top.

## Test plan
- Default config, enable=1, filt_data steps 0->500 at cycle 10 and holds -> evt_valid at cycle 19, evt_amp=500, evt_ts=10, single event only.
- peak_delay=0, filt_data ramps by 50/cycle from 0 -> sample at the first value >=100 (100); evt_valid the next cycle.
- evt_ready held 0, two pulses 40 cycles apart -> first event held stable, drop_cnt=1; after ready, 300 more held events saturate at 255.
- Write control=3 -> filt_clr high exactly one cycle; enable=0 mid-PEAK -> IDLE next cycle, no event produced.
- With V1_PILEUP_REJECT_EN, second crossing 5 cycles after the first -> no event, pileup_cnt=1, hold-off restarts; without the macro, one event from the first crossing.
- Assert reset during HOLD with evt_valid=1 -> next cycle all outputs 0, FSM IDLE, threshold reads default behaviour (crossing at 100).
